// File: rtl/register_file_banked.sv
// Banked register file with byte-lane writes, forwarding read ports, an internal
// auto-incrementing PC and a sequential valid/ready register dump engine.
module register_file_banked #(
  parameter int REG_WIDTH = 16,
  parameter int REG_COUNT = 8,
  parameter int RD_PORTS  = 2,
  parameter int PC_ADDR   = REG_COUNT - 1,
  parameter int PC_RESET  = 0,
  parameter int PC_STEP   = 2,
  localparam int AW       = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [REG_WIDTH-1:0]          wr_data,
  input  logic [RD_PORTS*AW-1:0]        rd_addr,
  input  logic [RD_PORTS-1:0]           rd_size,
  output logic [RD_PORTS*REG_WIDTH-1:0] rd_data,
  input  logic                          pc_inc,
  output logic [REG_WIDTH-1:0]          pc_out,
  input  logic                          dump_start,
  output logic                          dump_busy,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [AW-1:0]                 dump_addr,
  output logic [REG_WIDTH-1:0]          dump_data
);

  localparam int HALF = REG_WIDTH / 2;
  localparam logic [AW:0]          COUNT_W   = (AW + 1)'(REG_COUNT);
  localparam logic [AW-1:0]        LAST_IDX  = AW'(REG_COUNT - 1);
  localparam logic [REG_WIDTH-1:0] PC_RST_W  = REG_WIDTH'(PC_RESET);
  localparam logic [REG_WIDTH-1:0] PC_STEP_W = REG_WIDTH'(PC_STEP);

  typedef enum logic {IDLE, SEND} dump_state_t;

  logic [REG_WIDTH-1:0] regs [REG_COUNT];
  logic                 wr_ok;
  logic [REG_COUNT-1:0] wr_lo, wr_hi;

  dump_state_t          state, state_nx;
  logic [AW-1:0]        idx, idx_nx;

  logic [AW-1:0]        rd_a;
  logic [REG_WIDTH-1:0] rd_word;

  assign wr_ok  = {1'b0, wr_addr} < COUNT_W;
  assign pc_out = regs[PC_ADDR];

  always_comb begin
    wr_lo = '0;
    wr_hi = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      wr_lo[i] = wr_ok && (wr_addr == AW'(i)) && wr_en[0];
      wr_hi[i] = wr_ok && (wr_addr == AW'(i)) && wr_en[1];
    end
  end

  // A lane write to the PC suppresses the increment; the unwritten lane keeps its old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++)
        regs[i] <= (i == PC_ADDR) ? PC_RST_W : '0;
    end else begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        if (i == PC_ADDR && pc_inc && !wr_lo[i] && !wr_hi[i])
          regs[i] <= regs[i] + PC_STEP_W;
        if (wr_lo[i])
          regs[i][HALF-1:0] <= wr_data[HALF-1:0];
        if (wr_hi[i])
          regs[i][REG_WIDTH-1:HALF] <= wr_data[REG_WIDTH-1:HALF];
      end
    end
  end

  // Out-of-range read indices match no register and cannot match a valid write, so they read 0.
  always_comb begin
    rd_data = '0;
    rd_a    = '0;
    rd_word = '0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      rd_a    = rd_addr[p*AW +: AW];
      rd_word = '0;
      for (int unsigned i = 0; i < REG_COUNT; i++)
        if (rd_a == AW'(i))
          rd_word = regs[i];
      if (wr_ok && wr_addr == rd_a && wr_en[0])
        rd_word[HALF-1:0] = wr_data[HALF-1:0];
      if (wr_ok && wr_addr == rd_a && wr_en[1])
        rd_word[REG_WIDTH-1:HALF] = wr_data[REG_WIDTH-1:HALF];
      if (!rd_size[p])
        rd_word[REG_WIDTH-1:HALF] = {HALF{rd_word[HALF-1]}};
      rd_data[p*REG_WIDTH +: REG_WIDTH] = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    dump_busy  = 1'b0;
    dump_valid = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_nx = SEND;
          idx_nx   = '0;
        end
      end
      SEND: begin
        dump_busy  = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx == LAST_IDX) begin
            state_nx = IDLE;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + AW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dump_addr = idx;

  always_comb begin
    dump_data = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++)
      if (idx == AW'(i))
        dump_data = regs[i];
  end

endmodule

// File: tb/tb_register_file_banked.sv
// Scoreboard bench for register_file_banked: stimulus queues expected probe values
// and dump beats; a negedge monitor pops and compares them.
module tb_register_file_banked;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int RP = 2;
  localparam int AW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        wr_en;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic [RP*AW-1:0]  rd_addr;
  logic [RP-1:0]     rd_size;
  logic [RP*W-1:0]   rd_data;
  logic              pc_inc;
  logic [W-1:0]      pc_out;
  logic              dump_start;
  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [AW-1:0]     dump_addr;
  logic [W-1:0]      dump_data;

  register_file_banked #(
    .REG_WIDTH(W),
    .REG_COUNT(N),
    .RD_PORTS (RP),
    .PC_ADDR  (7),
    .PC_RESET (0),
    .PC_STEP  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_size   (rd_size),
    .rd_data   (rd_data),
    .pc_inc    (pc_inc),
    .pc_out    (pc_out),
    .dump_start(dump_start),
    .dump_busy (dump_busy),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr (dump_addr),
    .dump_data (dump_data)
  );

  always #5 clk = ~clk;

  // sel: 0 rd port0, 1 rd port1, 2 pc_out, 3 dump_valid, 4 dump_busy, 5 dump_addr
  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } probe_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } beat_t;

  probe_t pq[$];
  beat_t  dq[$];
  int     vectors = 0;
  int     miscompares = 0;

  task automatic probe(input int sel, input logic [15:0] exp, input string name);
    probe_t p;
    p.sel = sel; p.exp = exp; p.name = name;
    pq.push_back(p);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic s0,
                        input logic [AW-1:0] a1, input logic s1);
    rd_addr = {a1, a0};
    rd_size = {s1, s0};
  endtask

  always @(negedge clk) begin
    probe_t      p;
    beat_t       b;
    logic [15:0] act;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      case (p.sel)
        0:       act = rd_data[15:0];
        1:       act = rd_data[31:16];
        2:       act = pc_out;
        3:       act = {15'b0, dump_valid};
        4:       act = {15'b0, dump_busy};
        default: act = {13'b0, dump_addr};
      endcase
      vectors++;
      if (act !== p.exp) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", p.name, act, p.exp);
      end
    end
    if (dump_valid && dump_ready) begin
      vectors++;
      if (dq.size() == 0) begin
        miscompares++;
        $display("FAIL dump_extra_beat: got addr %0d data %h expected no beat", dump_addr, dump_data);
      end else begin
        b = dq.pop_front();
        if (dump_addr !== b.addr || dump_data !== b.data) begin
          miscompares++;
          $display("FAIL dump_beat: got addr %0d data %h expected addr %0d data %h",
                   dump_addr, dump_data, b.addr, b.data);
        end
      end
    end
  end

  task automatic check_dq_empty(input string name);
    vectors++;
    if (dq.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d beats outstanding expected 0", name, dq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    bit    done;
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; rd_size = '1; pc_inc = 1'b0;
    dump_start = 1'b0; dump_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < N; i++) begin
      set_rd(AW'(i), 1'b1, AW'(N - 1 - i), 1'b0);
      probe(0, 16'h0000, "reset_rd0");
      probe(1, 16'h0000, "reset_rd1");
      step();
    end
    probe(2, 16'h0000, "reset_pc");
    probe(3, 16'h0000, "reset_valid");
    probe(4, 16'h0000, "reset_busy");
    probe(5, 16'h0000, "reset_addr");
    step();

    // Byte-lane write and byte/word read sizing
    wr_en = 2'b11; wr_addr = 3; wr_data = 16'h12F4; step();
    wr_en = 2'b01; wr_data = 16'h0080; step();
    wr_en = 2'b00;
    set_rd(3, 1'b1, 3, 1'b0);
    probe(0, 16'h1280, "lane_word");
    probe(1, 16'hFF80, "lane_byte_sext");
    step();

    // Forwarding: high lane only, then both lanes
    wr_en = 2'b10; wr_addr = 5; wr_data = 16'hABCD;
    set_rd(5, 1'b1, 3, 1'b1);
    probe(0, 16'hAB00, "fwd_hi_lane");
    probe(1, 16'h1280, "fwd_other_addr");
    step();
    wr_en = 2'b11;
    set_rd(5, 1'b1, 5, 1'b0);
    probe(0, 16'hABCD, "fwd_both_word");
    probe(1, 16'hFFCD, "fwd_both_byte");
    step();
    wr_en = 2'b00;
    probe(0, 16'hABCD, "stored_after_fwd");
    step();

    // PC increment, wrap, write priority
    wr_en = 2'b11; wr_addr = 7; wr_data = 16'hFFFC; step();
    wr_en = 2'b00; pc_inc = 1'b1;
    probe(2, 16'hFFFC, "pc_load");
    step();
    probe(2, 16'hFFFE, "pc_inc1");
    step();
    probe(2, 16'h0000, "pc_wrap");
    wr_en = 2'b11; wr_addr = 7; wr_data = 16'h0100;
    set_rd(7, 1'b1, 7, 1'b1);
    probe(0, 16'h0100, "pc_fwd_read");
    step();
    wr_en = 2'b00; pc_inc = 1'b0;
    probe(2, 16'h0100, "pc_write_wins");
    step();
    wr_en = 2'b01; wr_addr = 7; wr_data = 16'h00AA; pc_inc = 1'b1;
    step();
    wr_en = 2'b00; pc_inc = 1'b0;
    probe(2, 16'h01AA, "pc_lane_write_wins");
    step();

    // Dump with toggling ready and a spurious mid-dump start
    for (int i = 0; i < N; i++) begin
      wr_en = 2'b11; wr_addr = AW'(i); wr_data = 16'h1000 + 16'(i);
      step();
    end
    wr_en = 2'b00;
    for (int i = 0; i < N; i++) begin
      b.addr = AW'(i); b.data = 16'h1000 + 16'(i);
      dq.push_back(b);
    end
    probe(3, 16'h0000, "idle_valid");
    dump_start = 1'b1; step();
    dump_start = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      dump_ready = (k % 2 == 0);
      dump_start = (k == 3);
      if (k == 1) probe(5, 16'h0001, "dump_hold_addr");
      step();
      dump_start = 1'b0;
      if (!dump_busy) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL dump_timeout: got busy expected idle within 40 cycles");
    end
    dump_ready = 1'b0;
    probe(4, 16'h0000, "dump_done_busy");
    probe(3, 16'h0000, "dump_done_valid");
    step(); step();
    check_dq_empty("dump_beat_count");

    // Reset during beat 3
    for (int i = 0; i < 3; i++) begin
      b.addr = AW'(i); b.data = 16'h1000 + 16'(i);
      dq.push_back(b);
    end
    dump_start = 1'b1; step();
    dump_start = 1'b0; dump_ready = 1'b1;
    step(); step(); step();
    dump_ready = 1'b0; rst = 1'b1;
    probe(5, 16'h0003, "abort_beat_addr");
    step();
    rst = 1'b0;
    probe(3, 16'h0000, "abort_valid");
    probe(4, 16'h0000, "abort_busy");
    probe(2, 16'h0000, "abort_pc");
    for (int i = 0; i < N; i++) begin
      set_rd(AW'(i), 1'b1, AW'(i), 1'b1);
      probe(0, 16'h0000, "abort_cleared");
      step();
    end
    check_dq_empty("abort_beat_count");
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_file_banked.md
Name: register_file_banked

Overview:
Parametrised successor to the CPU's 16-bit register file, used in the XMakina multi-cycle datapath.
- N read ports with byte/word read sizing and same-cycle write-to-read forwarding.
- PC owned internally at a parametrised address, with auto-increment.
- Sequential debug dump engine that streams every register over a valid/ready handshake, replacing the wide debug output bus.

Parameters:
REG_WIDTH, 16, register width in bits; must be even (HALF = REG_WIDTH/2).
REG_COUNT, 8, number of registers; AW = $clog2(REG_COUNT), minimum 1.
RD_PORTS, 2, number of combinational read ports.
PC_ADDR, REG_COUNT-1, index of the register acting as PC.
PC_RESET, 0, PC value after reset.
PC_STEP, 2, amount added to PC on pc_inc.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
wr_en  in  2  byte-lane write enables: bit0 = low half, bit1 = high half.
wr_addr  in  AW  write register index.
wr_data  in  REG_WIDTH  write data.
rd_addr  in  RD_PORTS*AW  packed read indices; port p uses slice p.
rd_size  in  RD_PORTS  per port: 1 = word, 0 = byte sign-extended.
rd_data  out  RD_PORTS*REG_WIDTH  packed read data.
pc_inc  in  1  advance PC by PC_STEP.
pc_out  out  REG_WIDTH  current PC register value (registered, no forwarding).
dump_start  in  1  request a full register dump.
dump_busy  out  1  dump in progress.
dump_valid  out  1  dump beat valid.
dump_ready  in  1  consumer accepts beat.
dump_addr  out  AW  index of the current beat.
dump_data  out  REG_WIDTH  register contents for the current beat.

Behaviour:
- Reset (rst=1 at clk edge):
  - All registers except PC clear to 0; PC loads PC_RESET.
  - Dump FSM goes to IDLE: dump_busy=0, dump_valid=0, dump_addr=0.
  - rst has priority over every other input.
- Write:
  - Each lane updates independently at the clock edge. The low lane writes bits HALF-1:0; the high lane writes REG_WIDTH-1:HALF. The other lane is preserved.
  - Index values ≥ REG_COUNT are ignored, with no write.
- Read:
  - Combinational, zero latency.
  - Per lane: if wr_en for that lane is set and wr_addr==rd_addr[p], that lane returns wr_data (forwarding). Otherwise it returns stored contents.
  - rd_size[p]=0 replaces the upper half with copies of bit HALF-1 of the forwarded/stored value.
  - Out-of-range rd_addr returns 0.
- PC:
  - Stored in the register at PC_ADDR; readable through any read port, with forwarding.
  - pc_inc=1 with no write to PC_ADDR: PC <= PC + PC_STEP, modulo 2^REG_WIDTH (wraps, e.g. 16'hFFFE + 2 = 0).
  - A write to PC_ADDR in the same cycle (either lane) wins and pc_inc is dropped. Unwritten lanes keep their old value, not the incremented one.
- Dump FSM, states IDLE and SEND:
  - IDLE: dump_valid=0, dump_busy=0. dump_start=1 → SEND next cycle with idx=0.
  - SEND: dump_busy=1, dump_valid=1, dump_addr=idx, dump_data = stored register[idx], live with no forwarding (a write accepted to idx shows from the next cycle).
  - A handshake (valid & ready) on idx=REG_COUNT-1 → IDLE. Otherwise idx++.
  - Without ready, the beat is held; dump_addr stays stable.
  - dump_start is ignored while in SEND. Register writes and pc_inc continue normally during a dump.
  - Reset mid-dump aborts immediately to IDLE with no further beats.
- Exactly REG_COUNT beats per dump, in ascending order; no beat is skipped or duplicated under any ready pattern.

Test Plan:
1. Reset, then read all ports → R0–R6 read 0, PC (R7) reads 0; pc_out=0; dump_valid=0.
2. Write R3 = 16'h12F4 with wr_en=2'b11. Next cycle write wr_en=2'b01, wr_data=16'h0080, to R3.
   - Read R3 with rd_size=1 → 16'h1280.
   - Read R3 with rd_size=0 → 16'hFF80.
3. Same cycle: wr_en=2'b11, R5 = 16'hABCD, rd_addr[0]=5 → rd_data[0]=16'hABCD before the edge. With wr_en=2'b10 instead, and R5 previously 0 → 16'hAB00.
4. Load PC = 16'hFFFC, then pc_inc for 2 cycles → pc_out = 16'hFFFE, then 16'h0000.
   - pc_inc together with a write of 16'h0100 to R7 → pc_out=16'h0100.
5. Preload R0..R7 with 16'h1000+i, then pulse dump_start.
   - With dump_ready toggling 1,0,1,0… → 8 beats, addr 0..7, data 16'h1000..16'h1007 (PC beat shows current PC). Then dump_busy=0.
   - A second dump_start mid-dump is ignored.
6. Assert rst during dump beat 3 → next cycle dump_valid=0, dump_busy=0, all registers cleared, PC = PC_RESET.
